// File: rtl/fmadd_add_round_stage.sv
// FMADD rounding/packing stage: applies the IEEE-754 rounding mode to a normalized
// mantissa, packs the result with exception flags, and buffers it behind a 2-entry skid.
module fmadd_add_round_stage #(
    parameter int std = 31,
    parameter int man = 22,
    parameter int exp = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [man+1:0] in_mantissa,
    input  logic [exp+1:0] in_exponent,
    input  logic           in_guard,
    input  logic           in_round,
    input  logic           in_sticky,
    input  logic           in_sign,
    input  logic [2:0]     in_rm,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [std:0]   out_result,
    output logic [4:0]     out_flags
);

    localparam logic [exp+2:0] EXP_TOP = (exp+3)'((1 << (exp+1)) - 1);

    // rest collapses everything below the rounding position into one bit
    function automatic logic round_up(input logic [2:0] rm, input logic sign,
                                      input logic lsb, input logic gd, input logic rest);
        case (rm)
            3'b001:  return 1'b0;
            3'b010:  return sign & (gd | rest);
            3'b011:  return ~sign & (gd | rest);
            3'b100:  return gd;
            default: return gd & (rest | lsb);
        endcase
    endfunction

    logic           hidden;
    logic           inc;
    logic           inc_w;
    logic           inexact;
    logic [man+2:0] sum;
    logic [man:0]   frac;
    logic [exp+2:0] exp_fin;
    logic           ovf;
    logic           ovf_inf;
    logic           tiny;
    logic           nx;
    logic           uf;
    logic [std:0]   new_result;
    logic [4:0]     new_flags;

    always_comb begin
        hidden  = in_mantissa[man+1];
        inexact = in_guard | in_round | in_sticky;
        inc     = round_up(in_rm, in_sign, in_mantissa[0], in_guard, in_round | in_sticky);
        inc_w   = round_up(in_rm, in_sign, in_guard, in_round, in_sticky);
        sum     = {1'b0, in_mantissa} + (man+3)'(inc);

        if (sum[man+2]) begin
            frac    = sum[man+1:1];
            exp_fin = {1'b0, in_exponent} + (exp+3)'(1);
        end else begin
            frac = sum[man:0];
            if (hidden)
                exp_fin = {1'b0, in_exponent};
            else if (sum[man+1])
                exp_fin = (exp+3)'(1);
            else
                exp_fin = '0;
        end

        ovf = (exp_fin >= EXP_TOP) | in_exponent[exp+1];
        case (in_rm)
            3'b001:  ovf_inf = 1'b0;
            3'b010:  ovf_inf = in_sign;
            3'b011:  ovf_inf = ~in_sign;
            default: ovf_inf = 1'b1;
        endcase

        // tininess is judged as if the exponent range were unbounded, i.e. after rounding
        tiny = ~hidden & ~((&in_mantissa[man:0]) & inc_w);
        nx   = inexact | ovf;
        uf   = tiny & nx;

        if (in_mantissa == '0 && !inexact) begin
            new_result = {in_sign, {(std){1'b0}}};
            new_flags  = '0;
        end else if (ovf) begin
            if (ovf_inf)
                new_result = {in_sign, {(exp+1){1'b1}}, {(man+1){1'b0}}};
            else
                new_result = {in_sign, {exp{1'b1}}, 1'b0, {(man+1){1'b1}}};
            new_flags = {2'b00, 1'b1, uf, 1'b1};
        end else begin
            new_result = {in_sign, exp_fin[exp:0], frac};
            new_flags  = {2'b00, 1'b0, uf, nx};
        end
    end

    logic         ready_q;
    logic         skid_valid;
    logic [std:0] skid_result;
    logic [4:0]   skid_flags;
    logic         accept;
    logic         out_free;
    logic         skid_next;

    assign in_ready = ready_q & ~rst;

    always_comb begin
        accept    = in_valid & in_ready;
        out_free  = ~out_valid | out_ready;
        skid_next = skid_valid ? ~out_free : (accept & ~out_free);
    end

    // the skid entry always drains into the output register ahead of any new input
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q     <= 1'b1;
            skid_valid  <= 1'b0;
            skid_result <= '0;
            skid_flags  <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_flags   <= '0;
        end else begin
            ready_q    <= ~skid_next;
            skid_valid <= skid_next;
            if (out_free) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_result <= skid_result;
                    out_flags  <= skid_flags;
                end else if (accept) begin
                    out_valid  <= 1'b1;
                    out_result <= new_result;
                    out_flags  <= new_flags;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_result <= new_result;
                skid_flags  <= new_flags;
            end
        end
    end

endmodule

// File: tb/tb_fmadd_add_round_stage.sv
// Directed-vector bench for the FMADD round/pack stage with hand-computed results.
module tb_fmadd_add_round_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_mantissa;
    logic [8:0]  in_exponent;
    logic        in_guard, in_round, in_sticky, in_sign;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_flags;

    int checks = 0;
    int passed = 0;

    localparam logic [2:0] RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100;

    fmadd_add_round_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mantissa(in_mantissa), .in_exponent(in_exponent),
        .in_guard(in_guard), .in_round(in_round), .in_sticky(in_sticky),
        .in_sign(in_sign), .in_rm(in_rm), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    task automatic set_inputs(input logic sign, input logic [23:0] mant, input logic [8:0] ex,
                              input logic g, input logic r, input logic s, input logic [2:0] rm);
        in_sign     = sign;
        in_mantissa = mant;
        in_exponent = ex;
        in_guard    = g;
        in_round    = r;
        in_sticky   = s;
        in_rm       = rm;
    endtask

    // present one operand set for exactly one edge, then return 1 time unit after it
    task automatic issue(input logic sign, input logic [23:0] mant, input logic [8:0] ex,
                         input logic g, input logic r, input logic s, input logic [2:0] rm);
        @(posedge clk);
        #1;
        set_inputs(sign, mant, ex, g, r, s, rm);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid);
        else passed++;
        checks++;
        if (out_result !== 32'h0) $display("[TB] FAIL reset_result got %h want 00000000", out_result);
        else passed++;
        checks++;
        if (out_flags !== 5'h0) $display("[TB] FAIL reset_flags got %h want 00", out_flags);
        else passed++;
        checks++;
        if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got %0b want 0", in_ready);
        else passed++;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL post_reset_in_ready got %0b want 1", in_ready);
        else passed++;
    endtask

    task automatic test_rne_carry;
        issue(1'b0, 24'hFFFFFF, 9'h07E, 1'b1, 1'b0, 1'b0, RNE);
        checks++;
        if (out_valid !== 1'b1) $display("[TB] FAIL carry_latency got %0b want 1", out_valid);
        else passed++;
        checks++;
        if (out_result !== 32'h3F800000 || out_flags !== 5'h01)
            $display("[TB] FAIL rne_carry got %h/%h want 3f800000/01", out_result, out_flags);
        else passed++;
    endtask

    task automatic test_overflow;
        issue(1'b0, 24'hFFFFFF, 9'h0FE, 1'b1, 1'b0, 1'b0, RNE);
        checks++;
        if (out_result !== 32'h7F800000 || out_flags !== 5'h05)
            $display("[TB] FAIL ovf_rne got %h/%h want 7f800000/05", out_result, out_flags);
        else passed++;
        issue(1'b0, 24'hFFFFFF, 9'h0FE, 1'b1, 1'b0, 1'b0, RTZ);
        checks++;
        if (out_result !== 32'h7F7FFFFF)
            $display("[TB] FAIL ovf_rtz_result got %h want 7f7fffff", out_result);
        else passed++;
        issue(1'b0, 24'hFFFFFF, 9'h100, 1'b1, 1'b0, 1'b0, RTZ);
        checks++;
        if (out_result !== 32'h7F7FFFFF || out_flags !== 5'h05)
            $display("[TB] FAIL ovf_rtz_range got %h/%h want 7f7fffff/05", out_result, out_flags);
        else passed++;
        issue(1'b0, 24'h800000, 9'h100, 1'b0, 1'b0, 1'b0, RDN);
        checks++;
        if (out_result !== 32'h7F7FFFFF || out_flags !== 5'h05)
            $display("[TB] FAIL ovf_rdn_pos got %h/%h want 7f7fffff/05", out_result, out_flags);
        else passed++;
        issue(1'b1, 24'h800000, 9'h100, 1'b0, 1'b0, 1'b0, RDN);
        checks++;
        if (out_result !== 32'hFF800000 || out_flags !== 5'h05)
            $display("[TB] FAIL ovf_rdn_neg got %h/%h want ff800000/05", out_result, out_flags);
        else passed++;
        issue(1'b0, 24'h800000, 9'h100, 1'b0, 1'b0, 1'b0, RUP);
        checks++;
        if (out_result !== 32'h7F800000 || out_flags !== 5'h05)
            $display("[TB] FAIL ovf_rup_pos got %h/%h want 7f800000/05", out_result, out_flags);
        else passed++;
    endtask

    task automatic test_subnormal;
        issue(1'b0, 24'h7FFFFF, 9'h000, 1'b1, 1'b1, 1'b0, RNE);
        checks++;
        if (out_result !== 32'h00800000 || out_flags !== 5'h01)
            $display("[TB] FAIL sub_to_normal got %h/%h want 00800000/01", out_result, out_flags);
        else passed++;
        issue(1'b0, 24'h400000, 9'h000, 1'b1, 1'b1, 1'b0, RNE);
        checks++;
        if (out_result !== 32'h00400001 || out_flags !== 5'h03)
            $display("[TB] FAIL sub_tiny got %h/%h want 00400001/03", out_result, out_flags);
        else passed++;
    endtask

    task automatic test_directed_modes;
        issue(1'b1, 24'h800000, 9'h07F, 1'b0, 1'b0, 1'b1, RDN);
        checks++;
        if (out_result !== 32'hBF800001 || out_flags !== 5'h01)
            $display("[TB] FAIL rdn_neg got %h/%h want bf800001/01", out_result, out_flags);
        else passed++;
        issue(1'b1, 24'h800000, 9'h07F, 1'b0, 1'b0, 1'b1, RUP);
        checks++;
        if (out_result !== 32'hBF800000 || out_flags !== 5'h01)
            $display("[TB] FAIL rup_neg got %h/%h want bf800000/01", out_result, out_flags);
        else passed++;
        issue(1'b0, 24'h800000, 9'h07F, 1'b1, 1'b0, 1'b0, RMM);
        checks++;
        if (out_result !== 32'h3F800001 || out_flags !== 5'h01)
            $display("[TB] FAIL rmm_tie got %h/%h want 3f800001/01", out_result, out_flags);
        else passed++;
        issue(1'b0, 24'h800000, 9'h07F, 1'b1, 1'b0, 1'b0, RNE);
        checks++;
        if (out_result !== 32'h3F800000 || out_flags !== 5'h01)
            $display("[TB] FAIL rne_tie_even got %h/%h want 3f800000/01", out_result, out_flags);
        else passed++;
        issue(1'b0, 24'h800001, 9'h07F, 1'b1, 1'b0, 1'b0, 3'b111);
        checks++;
        if (out_result !== 32'h3F800002 || out_flags !== 5'h01)
            $display("[TB] FAIL rm_other_as_rne got %h/%h want 3f800002/01", out_result, out_flags);
        else passed++;
    endtask

    task automatic test_zero;
        issue(1'b1, 24'h000000, 9'h000, 1'b0, 1'b0, 1'b0, RNE);
        checks++;
        if (out_result !== 32'h80000000 || out_flags !== 5'h00)
            $display("[TB] FAIL exact_zero got %h/%h want 80000000/00", out_result, out_flags);
        else passed++;
    endtask

    task automatic test_backpressure;
        int acc = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_inputs(1'b0, 24'hFFFFFF, 9'h07E, 1'b1, 1'b0, 1'b0, RNE);
        for (int i = 0; i < 3; i++) begin
            if (in_valid && in_ready) acc++;
            @(posedge clk);
            #1;
            if (i == 0) set_inputs(1'b1, 24'h800000, 9'h07F, 1'b0, 1'b0, 1'b1, RDN);
            if (i == 1) set_inputs(1'b1, 24'h000000, 9'h000, 1'b0, 1'b0, 1'b0, RNE);
        end
        checks++;
        if (acc !== 2) $display("[TB] FAIL bp_accepted got %0d want 2", acc);
        else passed++;
        checks++;
        if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready got %0b want 0", in_ready);
        else passed++;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h3F800000)
            $display("[TB] FAIL bp_hold got %0b/%h want 1/3f800000", out_valid, out_result);
        else passed++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'hBF800001 || in_ready !== 1'b1)
            $display("[TB] FAIL bp_second got %0b/%h/%0b want 1/bf800001/1", out_valid, out_result, in_ready);
        else passed++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h80000000)
            $display("[TB] FAIL bp_third got %0b/%h want 1/80000000", out_valid, out_result);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL bp_drained got %0b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_reset_full;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_inputs(1'b0, 24'hFFFFFF, 9'h07E, 1'b1, 1'b0, 1'b0, RNE);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'h0)
            $display("[TB] FAIL rst_full got %0b/%h want 0/00000000", out_valid, out_result);
        else passed++;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) $display("[TB] FAIL rst_no_stale cycle %0d got %0b want 0", i, out_valid);
            else passed++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_inputs(1'b0, 24'h0, 9'h0, 1'b0, 1'b0, 1'b0, RNE);
        test_reset;
        test_rne_carry;
        test_overflow;
        test_subnormal;
        test_directed_modes;
        test_zero;
        test_backpressure;
        test_reset_full;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
